// File: rtl/tlp_tx_arbiter.sv
// Round-robin arbiter sharing one TLP transmit channel between NREQ requesters.
// The winner owns the TLP-out bundle from upstream grant until its last beat is accepted.
module tlp_tx_arbiter #(
    parameter int unsigned NREQ = 3
) (
    input  logic                sys_clk,
    input  logic                sys_reset_n,
    input  logic [NREQ-1:0]     req_to_send,
    output logic [NREQ-1:0]     req_grant,
    input  logic [NREQ*7-1:0]   req_fmt_type,
    input  logic [NREQ*10-1:0]  req_length_in_dw,
    input  logic [NREQ*64-1:0]  req_address,
    input  logic [NREQ*8-1:0]   req_ldwbe_fdwbe,
    input  logic [NREQ*2-1:0]   req_attr,
    input  logic [NREQ*24-1:0]  req_transaction_id,
    input  logic [NREQ*13-1:0]  req_byte_count,
    input  logic [NREQ*7-1:0]   req_lower_address,
    input  logic [NREQ*64-1:0]  req_data,
    input  logic [NREQ-1:0]     req_src_rdy_n,
    output logic [NREQ-1:0]     req_dst_rdy_n,
    output logic                tlp_out_req_to_send,
    input  logic                tlp_out_grant,
    output logic [6:0]          tlp_out_fmt_type,
    output logic [9:0]          tlp_out_length_in_dw,
    output logic [63:0]         tlp_out_address,
    output logic [7:0]          tlp_out_ldwbe_fdwbe,
    output logic [1:0]          tlp_out_attr,
    output logic [23:0]         tlp_out_transaction_id,
    output logic [12:0]         tlp_out_byte_count,
    output logic [6:0]          tlp_out_lower_address,
    output logic [63:0]         tlp_out_data,
    output logic                tlp_out_src_rdy_n,
    input  logic                tlp_out_dst_rdy_n
);
    localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {StIdle, StReq, StXfer} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] winner_q, winner_d, last_q;
    logic [9:0]      cnt_q, load_cnt;
    logic            found, sel_payload, beat_ok, last_beat;
    logic [9:0]      sel_len;
    logic [10:0]     sel_dw;
    int unsigned     idx;

    // First requesting index after the previous winner, wrapping around.
    always_comb begin
        found    = 1'b0;
        winner_d = last_q;
        idx      = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(last_q) + k) % NREQ;
            if (!found && req_to_send[idx]) begin
                found    = 1'b1;
                winner_d = IdxW'(idx);
            end
        end
    end

    // Beat count of the selected packet: ceil(L/2) for payload TLPs, L=0 meaning 1024.
    always_comb begin
        sel_payload = req_fmt_type[32'(winner_d) * 7 + 6];
        sel_len     = req_length_in_dw[32'(winner_d) * 10 +: 10];
        sel_dw      = (sel_len == 10'd0) ? 11'd1024 : {1'b0, sel_len};
        load_cnt    = sel_payload ? 10'((sel_dw + 11'd1) >> 1) : 10'd1;
    end

    assign beat_ok   = (state_q == StXfer) && !tlp_out_src_rdy_n && !tlp_out_dst_rdy_n;
    assign last_beat = beat_ok && (cnt_q == 10'd1);

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (found) state_d = StReq;
            StReq:   if (tlp_out_grant) state_d = StXfer;
            StXfer:  if (last_beat) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            winner_q <= '0;
            last_q   <= IdxW'(NREQ - 1);
            cnt_q    <= '0;
        end else if (state_q == StIdle && found) begin
            winner_q <= winner_d;
            cnt_q    <= load_cnt;
        end else if (beat_ok) begin
            cnt_q <= cnt_q - 10'd1;
            if (last_beat) last_q <= winner_q;
        end
    end

    always_comb begin
        req_grant              = '0;
        req_dst_rdy_n          = '1;
        tlp_out_req_to_send    = 1'b0;
        tlp_out_src_rdy_n      = 1'b1;
        tlp_out_fmt_type       = '0;
        tlp_out_length_in_dw   = '0;
        tlp_out_address        = '0;
        tlp_out_ldwbe_fdwbe    = '0;
        tlp_out_attr           = '0;
        tlp_out_transaction_id = '0;
        tlp_out_byte_count     = '0;
        tlp_out_lower_address  = '0;
        tlp_out_data           = '0;
        unique case (state_q)
            StReq: tlp_out_req_to_send = 1'b1;
            StXfer: begin
                req_grant[winner_q]     = 1'b1;
                req_dst_rdy_n[winner_q] = tlp_out_dst_rdy_n;
                tlp_out_src_rdy_n       = req_src_rdy_n[winner_q];
                tlp_out_fmt_type        = req_fmt_type[32'(winner_q) * 7 +: 7];
                tlp_out_length_in_dw    = req_length_in_dw[32'(winner_q) * 10 +: 10];
                tlp_out_address         = req_address[32'(winner_q) * 64 +: 64];
                tlp_out_ldwbe_fdwbe     = req_ldwbe_fdwbe[32'(winner_q) * 8 +: 8];
                tlp_out_attr            = req_attr[32'(winner_q) * 2 +: 2];
                tlp_out_transaction_id  = req_transaction_id[32'(winner_q) * 24 +: 24];
                tlp_out_byte_count      = req_byte_count[32'(winner_q) * 13 +: 13];
                tlp_out_lower_address   = req_lower_address[32'(winner_q) * 7 +: 7];
                tlp_out_data            = req_data[32'(winner_q) * 64 +: 64];
            end
            default: ;
        endcase
    end
endmodule
